// File: rtl/sa_feed_skew_if.sv
// Tile input handshake plus skewed array-edge outputs of the systolic feeder.
interface sa_feed_skew_if #(
  parameter int data_width = 19,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_WIDTH    = 8
);
  logic                       start;
  logic [K_WIDTH-1:0]         k_len;
  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*data_width-1:0] in_act;
  logic [COLS*data_width-1:0] in_weight;
  logic [ROWS*data_width-1:0] act_left;
  logic [COLS*data_width-1:0] weight_above;
  logic                       w_en;
  logic                       w_compute;
  logic                       busy;
  logic                       done;

  modport master (
    output start, k_len, in_valid, in_act, in_weight,
    input  in_ready, act_left, weight_above, w_en, w_compute, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, in_act, in_weight,
    output in_ready, act_left, weight_above, w_en, w_compute, busy, done
  );
endinterface

// File: rtl/sa_feed_skew.sv
// Skews a K-vector tile onto the systolic array edges and drives w_en/w_compute through the drain.
// Lane r/c lands r/c steps after lane 0; in_valid gaps freeze every chain stage, nothing is lost.
module sa_feed_skew #(
  parameter int data_width = 19,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_WIDTH    = 8
) (
  input logic         clk,
  input logic         rst_n,
  sa_feed_skew_if.slave bus
);

  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [FW-1:0] FCNT_LAST = (FLUSH_LEN > 0) ? FW'(FLUSH_LEN - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [K_WIDTH-1:0] cnt, cnt_nxt;
  logic [FW-1:0]      fcnt, fcnt_nxt;
  logic               step;
  logic               feed_live;
  logic               w_compute_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LOAD;
          cnt_nxt   = bus.k_len;
        end
      end
      LOAD: state_nxt = (cnt != '0) ? STREAM : DONE;
      STREAM: begin
        if (bus.in_valid) begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == K_WIDTH'(1)) begin
            fcnt_nxt  = '0;
            state_nxt = (FLUSH_LEN == 0) ? DONE : FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fcnt == FCNT_LAST) state_nxt = DONE;
        else                   fcnt_nxt  = fcnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A step is either an accepted vector or a drain cycle injecting zeros.
  assign feed_live = (state == STREAM);
  assign step      = (feed_live && bus.in_valid) || (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_compute_q <= 1'b0;
    else        w_compute_q <= step;
  end

  assign bus.in_ready  = feed_live;
  assign bus.w_en      = (state == LOAD);
  assign bus.done      = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.w_compute = w_compute_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_act
    logic [data_width-1:0] sr [0:r];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= r; i++) sr[i] <= '0;
      end else if (step) begin
        sr[0] <= feed_live ? bus.in_act[r*data_width +: data_width] : '0;
        for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
      end
    end
    assign bus.act_left[r*data_width +: data_width] = sr[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wgt
    logic [data_width-1:0] sr [0:c];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i <= c; i++) sr[i] <= '0;
      end else if (step) begin
        sr[0] <= feed_live ? bus.in_weight[c*data_width +: data_width] : '0;
        for (int i = 1; i <= c; i++) sr[i] <= sr[i-1];
      end
    end
    assign bus.weight_above[c*data_width +: data_width] = sr[c];
  end

endmodule

// File: tb/tb_sa_feed_skew.sv
// Randomized bench for sa_feed_skew: timing/skew model from the tile rules plus a 4x4 PE array model.
module tb_sa_feed_skew;
  localparam int DW   = 19;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int KW   = 8;
  localparam int FL   = R + C - 2;
  localparam int MAXC = 64;
  localparam int AW   = R * DW;
  localparam int WW   = C * DW;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sa_feed_skew_if #(.data_width(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW)) bus ();

  sa_feed_skew #(.data_width(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] va [0:15];
  logic [WW-1:0] vw [0:15];
  int            gap [0:15];

  logic          rec_wen  [0:MAXC-1];
  logic          rec_wc   [0:MAXC-1];
  logic          rec_rdy  [0:MAXC-1];
  logic          rec_busy [0:MAXC-1];
  logic [AW-1:0] rec_act  [0:MAXC-1];
  logic [WW-1:0] rec_wgt  [0:MAXC-1];
  int            n_rec;
  int            done_cyc;

  logic          exp_wc  [0:MAXC-1];
  logic          exp_rdy [0:MAXC-1];
  int            exp_done;

  // Output-stationary PE array driven by the feeder.
  logic [2*DW-1:0] pe_sum [0:R-1][0:C-1];
  logic [DW-1:0]   pe_a   [0:R-1][0:C-1];
  logic [DW-1:0]   pe_w   [0:R-1][0:C-1];

  function automatic logic [DW-1:0] a_in(input int r, input int c);
    if (c == 0) return bus.act_left[r*DW +: DW];
    return pe_a[r][c-1];
  endfunction

  function automatic logic [DW-1:0] w_in(input int r, input int c);
    if (r == 0) return bus.weight_above[c*DW +: DW];
    return pe_w[r-1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (bus.w_en) begin
          pe_sum[r][c] <= '0;
          pe_a[r][c]   <= '0;
          pe_w[r][c]   <= '0;
        end else if (bus.w_compute) begin
          pe_sum[r][c] <= pe_sum[r][c] + (2*DW)'(a_in(r, c)) * (2*DW)'(w_in(r, c));
          pe_a[r][c]   <= a_in(r, c);
          pe_w[r][c]   <= w_in(r, c);
        end
      end
    end
  end

  function automatic logic [AW-1:0] rand_act();
    return AW'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [WW-1:0] rand_wgt();
    return WW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Value lane `lane` must show on its s-th visible step: vector s-lane, or the flush zero.
  function automatic logic [DW-1:0] lane_ref(input int s, input int lane, input bit is_act, input int k);
    int idx;
    idx = s - lane;
    if (idx < 0 || idx >= k) return '0;
    return is_act ? va[idx][lane*DW +: DW] : vw[idx][lane*DW +: DW];
  endfunction

  // Cycle numbering starts at the start cycle: LOAD at 1, STREAM from 2, one step per accept or flush cycle.
  task automatic build_model(input int k);
    int a, last;
    for (int c = 0; c < MAXC; c++) begin
      exp_wc[c]  = 1'b0;
      exp_rdy[c] = 1'b0;
    end
    a = 2;
    last = 1;
    for (int i = 0; i < k; i++) begin
      if (a + 1 < MAXC) exp_wc[a+1] = 1'b1;
      last = a;
      a = a + 1 + gap[i];
    end
    if (k > 0) begin
      for (int c = 2; c <= last && c < MAXC; c++) exp_rdy[c] = 1'b1;
      for (int f = 1; f <= FL && last + 1 + f < MAXC; f++) exp_wc[last+1+f] = 1'b1;
      exp_done = last + 1 + FL;
    end else begin
      exp_done = 2;
    end
  endtask

  task automatic run_tile(input int k, input bit poke);
    int vi, gc;
    vi = 0;
    gc = 0;
    done_cyc = -1;
    n_rec = 0;
    for (int c = 0; c < MAXC; c++) begin
      bus.start     = (c == 0) || (poke && (c == 3 || c == k + 4));
      bus.k_len     = (c == 0) ? KW'(k) : KW'($urandom());
      bus.in_valid  = (vi < k) && (gc == 0);
      bus.in_act    = (vi < k) ? va[vi] : rand_act();
      bus.in_weight = (vi < k) ? vw[vi] : rand_wgt();
      @(negedge clk);
      rec_wen[c]  = bus.w_en;
      rec_wc[c]   = bus.w_compute;
      rec_rdy[c]  = bus.in_ready;
      rec_busy[c] = bus.busy;
      rec_act[c]  = bus.act_left;
      rec_wgt[c]  = bus.weight_above;
      n_rec = c + 1;
      if (done_cyc < 0 && bus.done) done_cyc = c;
      @(posedge clk);
      #1;
      if (bus.in_valid && rec_rdy[c]) begin
        vi++;
        if (vi < k) gc = gap[vi-1];
      end else if (gc > 0) begin
        gc--;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.in_valid = 1'b0;
    bus.in_act = '0;
    bus.in_weight = '0;
    #12;
    n_vec++; if (bus.act_left !== '0) begin n_err++; $display("FAIL reset_act: got %0h want 0", bus.act_left); end
    n_vec++; if (bus.weight_above !== '0) begin n_err++; $display("FAIL reset_wgt: got %0h want 0", bus.weight_above); end
    n_vec++; if ({bus.w_en, bus.w_compute, bus.in_ready, bus.busy, bus.done} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 00000", {bus.w_en, bus.w_compute, bus.in_ready, bus.busy, bus.done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      va[i] = rand_act() | {R{19'h1}};
      vw[i] = rand_wgt() | {C{19'h1}};
    end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.k_len = 8'd4;
    bus.in_valid = 1'b1; bus.in_act = va[0]; bus.in_weight = vw[0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_act = va[1]; bus.in_weight = vw[1];
    @(posedge clk); #1;
    bus.in_act = va[2]; bus.in_weight = vw[2];
    n_vec++; if (bus.act_left[DW-1:0] !== va[1][DW-1:0]) begin
      n_err++; $display("FAIL prereset_lane0: got %0h want %0h", bus.act_left[DW-1:0], va[1][DW-1:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.act_left !== '0 || bus.weight_above !== '0) begin
      n_err++; $display("FAIL midreset_data: got %0h/%0h want 0/0", bus.act_left, bus.weight_above);
    end
    n_vec++; if ({bus.w_compute, bus.in_ready, bus.busy} !== 3'b0) begin
      n_err++; $display("FAIL midreset_ctl: got %b want 000", {bus.w_compute, bus.in_ready, bus.busy});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.in_ready, bus.busy, bus.w_compute} !== 3'b0) begin
      n_err++; $display("FAIL post_reset_idle: got %b want 000", {bus.in_ready, bus.busy, bus.w_compute});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_skew();
    int s, nwen, ovl;
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < R; r++) va[i][r*DW +: DW] = DW'((r + 1) * (i + 1));
      for (int c = 0; c < C; c++) vw[i][c*DW +: DW] = DW'((c + 1) * (i + 1));
    end
    for (int i = 0; i < 16; i++) gap[i] = 0;
    build_model(3);
    run_tile(3, 1'b0);
    n_vec++; if (done_cyc !== 11 || exp_done != 11) begin n_err++; $display("FAIL skew_done: got %0d want 11", done_cyc); end
    nwen = 0;
    ovl = 0;
    for (int c = 0; c < n_rec; c++) begin
      if (rec_wen[c]) nwen++;
      if (rec_wen[c] && rec_wc[c]) ovl++;
    end
    n_vec++; if (nwen != 1 || rec_wen[1] !== 1'b1) begin n_err++; $display("FAIL skew_wen: got %0d pulses want 1 at cycle 1", nwen); end
    n_vec++; if (ovl != 0) begin n_err++; $display("FAIL skew_overlap: got %0d want 0", ovl); end
    s = 0;
    for (int c = 0; c < n_rec; c++) begin
      n_vec++; if (rec_wc[c] !== exp_wc[c]) begin n_err++; $display("FAIL skew_wc[%0d]: got %b want %b", c, rec_wc[c], exp_wc[c]); end
      n_vec++; if (rec_rdy[c] !== exp_rdy[c]) begin n_err++; $display("FAIL skew_rdy[%0d]: got %b want %b", c, rec_rdy[c], exp_rdy[c]); end
      if (rec_wc[c]) begin
        for (int r = 0; r < R; r++) begin
          n_vec++; if (rec_act[c][r*DW +: DW] !== lane_ref(s, r, 1'b1, 3)) begin
            n_err++; $display("FAIL skew_act s%0d r%0d: got %0h want %0h", s, r, rec_act[c][r*DW +: DW], lane_ref(s, r, 1'b1, 3));
          end
        end
        for (int cc = 0; cc < C; cc++) begin
          n_vec++; if (rec_wgt[c][cc*DW +: DW] !== lane_ref(s, cc, 1'b0, 3)) begin
            n_err++; $display("FAIL skew_wgt s%0d c%0d: got %0h want %0h", s, cc, rec_wgt[c][cc*DW +: DW], lane_ref(s, cc, 1'b0, 3));
          end
        end
        s++;
      end
    end
    n_vec++; if (s != 3 + FL) begin n_err++; $display("FAIL skew_steps: got %0d want %0d", s, 3 + FL); end
  endtask

  task automatic test_stalls();
    int s;
    for (int i = 0; i < 16; i++) gap[i] = 0;
    gap[0] = 2;
    build_model(3);
    run_tile(3, 1'b0);
    n_vec++; if (done_cyc !== 13) begin n_err++; $display("FAIL stall_done: got %0d want 13", done_cyc); end
    s = 0;
    for (int c = 0; c < n_rec; c++) begin
      n_vec++; if (rec_wc[c] !== exp_wc[c]) begin n_err++; $display("FAIL stall_wc[%0d]: got %b want %b", c, rec_wc[c], exp_wc[c]); end
      if (rec_wc[c]) begin
        for (int r = 0; r < R; r++) begin
          n_vec++; if (rec_act[c][r*DW +: DW] !== lane_ref(s, r, 1'b1, 3) || rec_wgt[c][r*DW +: DW] !== lane_ref(s, r, 1'b0, 3)) begin
            n_err++; $display("FAIL stall_lane s%0d l%0d: got %0h/%0h want %0h/%0h", s, r, rec_act[c][r*DW +: DW],
                              rec_wgt[c][r*DW +: DW], lane_ref(s, r, 1'b1, 3), lane_ref(s, r, 1'b0, 3));
          end
        end
        s++;
      end
    end
  endtask

  task automatic test_empty();
    int nwen, nwc, nrdy;
    for (int i = 0; i < 16; i++) gap[i] = 0;
    build_model(0);
    run_tile(0, 1'b0);
    nwen = 0; nwc = 0; nrdy = 0;
    for (int c = 0; c < n_rec; c++) begin
      if (rec_wen[c]) nwen++;
      if (rec_wc[c]) nwc++;
      if (rec_rdy[c]) nrdy++;
    end
    n_vec++; if (done_cyc !== exp_done) begin n_err++; $display("FAIL empty_done: got %0d want %0d", done_cyc, exp_done); end
    n_vec++; if (nwen != 1 || rec_wen[1] !== 1'b1) begin n_err++; $display("FAIL empty_wen: got %0d want 1 at cycle 1", nwen); end
    n_vec++; if (nwc != 0) begin n_err++; $display("FAIL empty_wc: got %0d want 0", nwc); end
    n_vec++; if (nrdy != 0) begin n_err++; $display("FAIL empty_rdy: got %0d want 0", nrdy); end
  endtask

  task automatic test_ignored();
    int nwc;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_act = rand_act();
      bus.in_weight = rand_wgt();
      @(negedge clk);
      n_vec++; if ({bus.busy, bus.in_ready, bus.w_compute} !== 3'b0) begin
        n_err++; $display("FAIL idle_valid[%0d]: got %b want 000", i, {bus.busy, bus.in_ready, bus.w_compute});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      va[i] = rand_act();
      vw[i] = rand_wgt();
      gap[i] = 0;
    end
    build_model(3);
    run_tile(3, 1'b1);
    nwc = 0;
    for (int c = 0; c < n_rec; c++) if (rec_wc[c]) nwc++;
    n_vec++; if (done_cyc !== exp_done) begin n_err++; $display("FAIL ign_done: got %0d want %0d", done_cyc, exp_done); end
    n_vec++; if (nwc != 3 + FL) begin n_err++; $display("FAIL ign_steps: got %0d want %0d", nwc, 3 + FL); end
    n_vec++; if (done_cyc < 0 || rec_busy[done_cyc+1] !== 1'b0 || rec_busy[done_cyc+2] !== 1'b0) begin
      n_err++; $display("FAIL ign_idle_after: got busy after done, want idle");
    end
  endtask

  task automatic test_end_to_end();
    logic [2*DW-1:0] ref_sum;
    for (int i = 0; i < 4; i++) begin
      va[i] = rand_act();
      vw[i] = rand_wgt();
      gap[i] = $urandom_range(0, 2);
    end
    build_model(4);
    run_tile(4, 1'b0);
    n_vec++; if (done_cyc !== exp_done) begin n_err++; $display("FAIL e2e_done: got %0d want %0d", done_cyc, exp_done); end
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        ref_sum = '0;
        for (int k = 0; k < 4; k++)
          ref_sum = ref_sum + (2*DW)'(va[k][r*DW +: DW]) * (2*DW)'(vw[k][c*DW +: DW]);
        n_vec++; if (pe_sum[r][c] !== ref_sum) begin
          n_err++; $display("FAIL e2e_sum[%0d][%0d]: got %0h want %0h", r, c, pe_sum[r][c], ref_sum);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_skew();
    test_stalls();
    test_empty();
    test_ignored();
    for (int t = 0; t < 3; t++) test_end_to_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_feed_skew.md
# sa_feed_skew

Upstream feeder for the output-stationary systolic array of PE cells. Accepts one tile of K activation/weight vectors over a valid/ready handshake. Skews them so that row r activations and column c weights enter the array r and c steps late, respectively. Drives the array's `w_en`/`w_compute` controls, including the drain (flush) phase, so the PE at (ROWS-1, COLS-1) sees every product before `done`.

## Interface
- `data_width`, 19, width of one activation/weight element (matches PE).
- `ROWS`, 4, array rows (activation lanes), ≥1.
- `COLS`, 4, array columns (weight lanes), ≥1.
- `K_WIDTH`, 8, width of the tile-length field.

Clock and reset: one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst_n`.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a tile; sampled only in IDLE.
- `k_len` in K_WIDTH: number of vectors in the tile; sampled with `start`.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: high only in STREAM.
- `in_act` in ROWS*data_width: activations; lane r = bits [r*dw +: dw].
- `in_weight` in COLS*data_width: weights; lane c likewise.
- `act_left` out ROWS*data_width: to `active_left` of column-0 PEs, lane r to row r.
- `weight_above` out COLS*data_width: to `in_weight_above` of row-0 PEs.
- `w_en` out 1: PE accumulator load (clear) strobe.
- `w_compute` out 1: PE compute/shift enable, aligned with `act_left`/`weight_above`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle tile-complete pulse.

## Operation
States:
- **IDLE → LOAD** on `start`. `k_len` is latched into the counter.
- **LOAD** lasts 1 cycle; `w_en`=1.
  - Next state is STREAM if `k_len` ≠ 0, else DONE.
- **STREAM**: `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) is one *step*.
  - On the handshake carrying the k_len-th vector, go to FLUSH.
- **FLUSH**: every cycle is a step that injects zero vectors.
  - Lasts exactly ROWS+COLS-2 cycles, then DONE.
  - When ROWS+COLS-2 = 0, go straight to DONE.
- **DONE** lasts 1 cycle; `done`=1; then IDLE.

Datapath:
- Skew chains: lane r of act has r+1 register stages; lane c of weight has c+1 stages. The last stage is the output register.
- All stages shift only on a step; otherwise they hold. This gives global stall with no data loss.
- `w_compute` is a register loaded with the step signal every cycle. It is therefore high exactly in cycles where the outputs carry a freshly shifted value.
- Zeros injected in FLUSH give zero products, so sums are unaffected while in-flight data drains.
- No arithmetic is done here; data passes through bit-exact.

Boundaries:
- `start` outside IDLE is ignored. `in_valid` outside STREAM is ignored, with no consumption.
- `in_valid` low in STREAM stalls: no step, `w_compute`=0 next cycle, the counter holds.
- `w_en` and `w_compute` are never high in the same cycle.
- Reset mid-operation: all registers clear immediately; state returns to IDLE. There is no partial flush.

## Timing
- Reset values: `act_left`=0, `weight_above`=0, `w_en`=0, `w_compute`=0, `in_ready`=0, `busy`=0, `done`=0, state=IDLE, counter=0.
- `start` at cycle t gives LOAD (`w_en`=1) at t+1. STREAM, with `in_ready`=1, begins at t+2.
- Vector accepted at edge e:
  - Act lane r and weight lane r appear on outputs r steps after the first visible step.
  - Lane 0 is visible in the cycle after e, with `w_compute`=1.
- Without stalls, `start` to `done` = 2 + K + (ROWS+COLS-2) cycles. `done` is in the following cycle.
- `done` coincides with the final `w_compute` pulse. PE sums are final from the cycle after `done`.
- `in_ready` is a Moore output (state decode); there is no combinational path from `in_valid`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-STREAM with nonzero data in chains -> all outputs 0 in the same cycle; after release, IDLE with `in_ready`=0.
- **Skew and timing** (ROWS=COLS=4, K=3, vectors act=w={1,2,3,4}·k, no stalls):
  - lane r output equals vector k at step k+r;
  - `w_en` pulses once at t+1;
  - `w_compute` high for 3+6 consecutive cycles;
  - `done` at t+11.
- **Stalls:** same tile with `in_valid` low for 2 cycles between vectors -> `w_compute` has matching 0 gaps; output sequence per lane is identical; `done` is 2 cycles later.
- **Empty tile:** `k_len`=0 -> `w_en` 1 cycle then `done` the next cycle; `w_compute` never asserts; `in_ready` never asserts.
- **Ignored inputs:** `start` pulsed during STREAM and FLUSH; `in_valid` in IDLE -> no state change, no extra step.
- **End-to-end:** feeder plus 4x4 PE array, K=4, random 19-bit operands -> every PE `out_sum` equals the reference dot product (38-bit wrap) in the cycle after `done`.
